arcade_input_cond: RTL
======================

// Module: arcade_input_cond
// PURPOSE
//  Per-player input conditioner between the hps_io joystick words and the game core CONTROLS buses.
//  It synchronises raw joystick bits and resolves opposing directions.
//  It generates timed autofire, fixed-width coin pulses and a pause toggle.
//  Outputs are active-low control words, one per player, in core order
//  {coin,start2,start1,fire2,fire,up,down,left,right}.
//  Parametrised successor to the inline single-player mapping in the top-level, for N-player cores.
// PARAMETERS
//  NUM_PLAYERS   2          players; joystick words and control words per player
//  SYNC_STAGES   2          flip-flop depth of input synchroniser (>=2)
//  AF_HALF       333_333    autofire half-period in clk_sys cycles (30 Hz at 20 MHz)
//  COIN_PULSE    2_000_000  coin output width in clk_sys cycles (100 ms at 20 MHz)
//  SOCD_NEUTRAL  1          1: opposing directions held together -> both released
// PORTS
//  clk_sys      in   1                  system clock
//  reset_n      in   1                  async active-low reset
//  joy_in       in   16*NUM_PLAYERS     raw joystick words, player p at [16p+15:16p];
//                                        bits: 0 R,1 L,2 D,3 U,4 fire,5 fast fire,6 start1,7 start2,8 coin,9 pause
//  ctrl_n       out  9*NUM_PLAYERS      active-low control word per player, player p at [9p+8:9p]
//  pause_out    out  1                  pause request level to pause block
//  coin_busy    out  NUM_PLAYERS        1 while that player's coin pulse is running
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - ctrl_n = all 1s; pause_out = 0; coin_busy = 0.
//   - Synchronisers, autofire counters/phase and coin counters clear to 0.
//  Latency
//   - Direction, fire2 and start paths appear on ctrl_n SYNC_STAGES+1 cycles after a joy_in change.
//   - Applies to the no-autofire, no-coin cases.
//  Directions
//   - When SOCD_NEUTRAL=1: L&R both set -> L and R outputs inactive (1).
//   - When SOCD_NEUTRAL=1: U&D both set -> U and D outputs inactive (1).
//   - Single-direction holds pass through unchanged.
//   - When SOCD_NEUTRAL=0: all directions pass through unchanged.
//  Autofire (per player; a 0->1 transition is a rising edge)
//   - On a rising edge of synced bit5, af_phase=1 and the counter loads 0.
//   - While bit5 is held: the counter counts 0..AF_HALF-1. At AF_HALF-1 it wraps to 0 and af_phase toggles.
//   - fire output active = bit4 | (bit5 & af_phase).
//   - Releasing bit5 clears af_phase and the counter in the same cycle.
//   - The first autofire shot appears with the same latency as plain fire.
//  Coin (per player)
//   - A rising edge of synced bit8 with coin_busy=0 starts the pulse:
//     coin output active and coin_busy=1 for exactly COIN_PULSE cycles.
//   - Rising edges while busy are ignored, not queued.
//   - Holding coin never retriggers; a new pulse needs release then press after busy clears.
//   - A rising edge in the cycle busy clears does start a new pulse.
//  Pause
//   - Each rising edge of synced bit9 from any player toggles pause_out.
//   - Simultaneous edges from several players in one cycle count as one toggle.
//  Reset mid-operation
//   - Running coin pulses and autofire abort immediately and outputs go inactive.
//   - An input held through reset release does not produce an edge.
//     Edge detectors power up with the last-sample flop at 0 only after SYNC_STAGES cycles;
//     equivalently, edges are masked for SYNC_STAGES+1 cycles after reset release.
//  Widths and counters
//   - Counters are sized $clog2(COIN_PULSE) and $clog2(AF_HALF), no overflow.
//   - Players are fully independent except for pause_out.
// TESTING
//  1 P0 joy=bit0|bit1 (L+R) held, SOCD_NEUTRAL=1 -> ctrl_n[1:0]=2'b11 after 3 cycles; drop L -> ctrl_n[0]=0.
//  2 AF_HALF=4, P1 bit5 held 20 cycles -> P1 fire (ctrl_n[13]) pattern 0000 1111 0000 ...
//    Release -> 1 next cycle.
//  3 COIN_PULSE=10, P0 coin pressed 3 cycles -> coin low exactly 10 cycles.
//    Re-press at pulse cycle 5 ignored; coin_busy tracks the pulse.
//  4 Coin held 50 cycles with COIN_PULSE=10 -> single pulse; release and press -> second pulse.
//  5 P0 and P1 pause rising same cycle -> pause_out 0->1 once; P0 press again -> 1->0.
//  6 Assert reset_n=0 mid coin pulse and autofire -> ctrl_n all 1 immediately.
//    Release with coin held -> no new pulse.

Source files
------------

// File: rtl/arcade_input_cond.sv
// arcade_input_cond
//   Per-player input conditioner between the hps_io joystick words and the
//   game core CONTROLS buses. Each player's raw joystick bits are synchronised,
//   opposing directions are resolved, and the block adds timed autofire,
//   fixed-width coin pulses and a shared pause toggle. Outputs are
//   registered, active-low control words.
//
// Ports
//   clk_sys    in   1               system clock
//   reset_n    in   1               active-low reset; asserts asynchronously and
//                                   is expected to be released synchronously
//   joy_in     in   16*NUM_PLAYERS  raw joystick words, player p at [16p+15:16p]
//                                   bit 0 R, 1 L, 2 D, 3 U, 4 fire, 5 fast fire,
//                                   6 start1, 7 start2, 8 coin, 9 pause
//   ctrl_n     out  9*NUM_PLAYERS   player p at [9p+8:9p], core order
//                                   {coin,start2,start1,fire2,fire,up,down,left,right}
//   pause_out  out  1               pause request level
//   coin_busy  out  NUM_PLAYERS     high while that player's coin pulse runs
//
// The fast-fire button also drives fire2 directly, so cores with a second
// fire button still see it as a plain held button.

module arcade_player_cond #(
    parameter int SYNC_STAGES  = 2,
    parameter int AF_HALF      = 333_333,
    parameter int COIN_PULSE   = 2_000_000,
    parameter int SOCD_NEUTRAL = 1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        edge_en,
    input  logic [15:0] joy,
    output logic [8:0]  ctrl_n,
    output logic        coin_busy,
    output logic        pause_rise
);
    localparam int AF_W = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;
    localparam int CP_W = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;

    typedef struct packed {
        logic coin, start2, start1, fire2, fire, up, down, left, right;
    } ctrl_t;

    logic [SYNC_STAGES-1:0][9:0] sync_q;
    logic [9:0]                  js;
    logic                        prev_ff, prev_coin, prev_pause;
    logic                        ff_rise, coin_rise;
    logic [AF_W-1:0]             af_cnt, af_cnt_nxt;
    logic                        af_phase, af_phase_nxt;
    logic [CP_W-1:0]             cp_cnt;
    logic                        coin_last, coin_start;
    logic                        lr_clash, ud_clash;
    ctrl_t                       act;
    ctrl_t                       ctrl_q;
    logic                        unused_hi;

    assign unused_hi = ^joy[15:10];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q                            <= '0;
            {prev_pause, prev_coin, prev_ff}  <= '0;
        end else begin
            sync_q                            <= {sync_q[SYNC_STAGES-2:0], joy[9:0]};
            {prev_pause, prev_coin, prev_ff}  <= {js[9], js[8], js[5]};
        end
    end

    assign js = sync_q[SYNC_STAGES-1];

    // edge_en stays low until the synchroniser has flushed after reset, so a
    // button held through reset release is not seen as a press.
    assign ff_rise    = js[5] & ~prev_ff    & edge_en;
    assign coin_rise  = js[8] & ~prev_coin  & edge_en;
    assign pause_rise = js[9] & ~prev_pause & edge_en;

    // Autofire: phase is evaluated one step ahead so the first shot leaves
    // with the same latency as plain fire.
    always_comb begin
        af_cnt_nxt   = '0;
        af_phase_nxt = 1'b0;
        if (js[5]) begin
            if (ff_rise) begin
                af_phase_nxt = 1'b1;
            end else if (af_cnt == AF_W'(AF_HALF - 1)) begin
                af_phase_nxt = ~af_phase;
            end else begin
                af_cnt_nxt   = af_cnt + 1'b1;
                af_phase_nxt = af_phase;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else begin
            af_cnt   <= af_cnt_nxt;
            af_phase <= af_phase_nxt;
        end
    end

    // Coin: a press landing in the final pulse cycle restarts the pulse
    // back-to-back; any other press while busy is dropped.
    assign coin_last  = coin_busy && (cp_cnt == CP_W'(COIN_PULSE - 1));
    assign coin_start = coin_rise && (!coin_busy || coin_last);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            coin_busy <= 1'b0;
            cp_cnt    <= '0;
        end else if (coin_start) begin
            coin_busy <= 1'b1;
            cp_cnt    <= '0;
        end else if (coin_last) begin
            coin_busy <= 1'b0;
            cp_cnt    <= '0;
        end else if (coin_busy) begin
            cp_cnt    <= cp_cnt + 1'b1;
        end
    end

    always_comb begin
        lr_clash   = (SOCD_NEUTRAL != 0) && js[0] && js[1];
        ud_clash   = (SOCD_NEUTRAL != 0) && js[2] && js[3];
        act        = '0;
        act.right  = js[0] & ~lr_clash;
        act.left   = js[1] & ~lr_clash;
        act.down   = js[2] & ~ud_clash;
        act.up     = js[3] & ~ud_clash;
        act.fire   = js[4] | (js[5] & af_phase_nxt);
        act.fire2  = js[5];
        act.start1 = js[6];
        act.start2 = js[7];
        // next-state of coin_busy, so the coin bit tracks coin_busy exactly
        act.coin   = coin_start || (coin_busy && !coin_last);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) ctrl_q <= '1;
        else          ctrl_q <= ~act;
    end

    assign ctrl_n = ctrl_q;
endmodule

module arcade_input_cond #(
    parameter int NUM_PLAYERS  = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int AF_HALF      = 333_333,
    parameter int COIN_PULSE   = 2_000_000,
    parameter int SOCD_NEUTRAL = 1
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [16*NUM_PLAYERS-1:0] joy_in,
    output logic [9*NUM_PLAYERS-1:0] ctrl_n,
    output logic                     pause_out,
    output logic [NUM_PLAYERS-1:0]   coin_busy
);
    logic [NUM_PLAYERS-1:0][15:0] joy_w;
    logic [NUM_PLAYERS-1:0][8:0]  ctrl_w;
    logic [NUM_PLAYERS-1:0]       pause_rise;
    logic [SYNC_STAGES:0]         vld_pipe;

    assign joy_w  = joy_in;
    assign ctrl_n = ctrl_w;

    // Fills with ones after reset; the top bit gates edge detection until
    // SYNC_STAGES+1 cycles have passed.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) vld_pipe <= '0;
        else          vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
    end

    generate
        for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
            arcade_player_cond #(
                .SYNC_STAGES  (SYNC_STAGES),
                .AF_HALF      (AF_HALF),
                .COIN_PULSE   (COIN_PULSE),
                .SOCD_NEUTRAL (SOCD_NEUTRAL)
            ) u_player (
                .clk_sys    (clk_sys),
                .reset_n    (reset_n),
                .edge_en    (vld_pipe[SYNC_STAGES]),
                .joy        (joy_w[p]),
                .ctrl_n     (ctrl_w[p]),
                .coin_busy  (coin_busy[p]),
                .pause_rise (pause_rise[p])
            );
        end
    endgenerate

    // Several players pressing pause in the same cycle give one toggle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) pause_out <= 1'b0;
        else          pause_out <= pause_out ^ (|pause_rise);
    end
endmodule
